// File: rtl/mips_decode_exec_unit.sv
// Decode-and-execute slice: opcode decode, ALU control, 32-bit ALU and an
// EX/MEM-style output register with synchronous reset and flush (bubble).
module mips_decode_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_reg,
    input  logic [WIDTH-1:0] imm_se,
    output logic             regdst,
    output logic             branch,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic [3:0]       aluctl,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic [WIDTH-1:0] q_result,
    output logic             q_zero,
    output logic [WIDTH-1:0] q_store_data,
    output logic             q_regwrite,
    output logic             q_memtoreg,
    output logic             q_memread,
    output logic             q_memwrite,
    output logic             q_branch
);

    logic [WIDTH-1:0] w_alu_b;

    // Main decode: opcode to datapath control; unknown opcodes decode to a no-op.
    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        case (opcode)
            6'b000000: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = 2'b10;
            end
            6'b100011: begin
                alusrc   = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            6'b101011: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            6'b000100: begin
                branch = 1'b1;
                aluop  = 2'b01;
            end
            6'b001000: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control: op class plus funct field select the ALU operation.
    always_comb begin
        aluctl = 4'b1111;
        case (aluop)
            2'b00: aluctl = 4'b0010;
            2'b01: aluctl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: aluctl = 4'b0010;
                    6'b100010: aluctl = 4'b0110;
                    6'b100100: aluctl = 4'b0000;
                    6'b100101: aluctl = 4'b0001;
                    6'b100110: aluctl = 4'b1101;
                    6'b100111: aluctl = 4'b1100;
                    6'b101010: aluctl = 4'b0111;
                    default:   aluctl = 4'b1111;
                endcase
            end
            default: aluctl = 4'b1111;
        endcase
    end

    assign w_alu_b = alusrc ? imm_se : b_reg;

    // ALU datapath; illegal codes produce 0 so zero reads high for them.
    always_comb begin
        alu_out = '0;
        case (aluctl)
            4'b0010: alu_out = a + w_alu_b;
            4'b0110: alu_out = a - w_alu_b;
            4'b0000: alu_out = a & w_alu_b;
            4'b0001: alu_out = a | w_alu_b;
            4'b1101: alu_out = a ^ w_alu_b;
            4'b1100: alu_out = ~(a | w_alu_b);
            4'b0111: alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(w_alu_b))};
            default: alu_out = '0;
        endcase
    end

    assign zero = (alu_out == '0);

    // EX/MEM register: reset beats flush, flush beats load.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q_result     <= '0;
            q_zero       <= 1'b0;
            q_store_data <= '0;
            q_regwrite   <= 1'b0;
            q_memtoreg   <= 1'b0;
            q_memread    <= 1'b0;
            q_memwrite   <= 1'b0;
            q_branch     <= 1'b0;
        end else begin
            q_result     <= alu_out;
            q_zero       <= zero;
            q_store_data <= b_reg;
            q_regwrite   <= regwrite;
            q_memtoreg   <= memtoreg;
            q_memread    <= memread;
            q_memwrite   <= memwrite;
            q_branch     <= branch;
        end
    end

endmodule

// File: tb/tb_mips_decode_exec_unit.sv
// Directed vector bench for mips_decode_exec_unit plus reset/flush sequences.
module tb_mips_decode_exec_unit;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [5:0]  opcode, funct;
    logic [31:0] a, b_reg, imm_se;
    logic        regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] q_result, q_store_data;
    logic        q_zero, q_regwrite, q_memtoreg, q_memread, q_memwrite, q_branch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_decode_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .opcode(opcode), .funct(funct), .a(a), .b_reg(b_reg), .imm_se(imm_se),
        .regdst(regdst), .branch(branch), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrc(alusrc),
        .aluop(aluop), .aluctl(aluctl), .alu_out(alu_out), .zero(zero),
        .q_result(q_result), .q_zero(q_zero), .q_store_data(q_store_data),
        .q_regwrite(q_regwrite), .q_memtoreg(q_memtoreg), .q_memread(q_memread),
        .q_memwrite(q_memwrite), .q_branch(q_branch)
    );

    // ctl bit order: [6]regdst [5]alusrc [4]memtoreg [3]regwrite [2]memread [1]memwrite [0]branch
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vi;
        logic [6:0]  ctl;
        logic [1:0]  aop;
        logic [3:0]  actl;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vi);
        opcode = op; funct = fn; a = va; b_reg = vb; imm_se = vi;
    endtask

    task automatic check_q_clear(input string nm);
        check({nm, ".q_result"},     q_result, 32'h0);
        check({nm, ".q_store_data"}, q_store_data, 32'h0);
        check({nm, ".q_flags"},
              {26'h0, q_zero, q_regwrite, q_memtoreg, q_memread, q_memwrite, q_branch}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{"add",      6'b000000, 6'b100000, 32'd5,        32'd7,        32'd0,        7'b1001000, 2'b10, 4'b0010, 32'd12,       1'b0};
        vecs[1]  = '{"sub0",     6'b000000, 6'b100010, 32'd9,        32'd9,        32'd0,        7'b1001000, 2'b10, 4'b0110, 32'd0,        1'b1};
        vecs[2]  = '{"slt_neg",  6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd0,        7'b1001000, 2'b10, 4'b0111, 32'd1,        1'b0};
        vecs[3]  = '{"slt_pos",  6'b000000, 6'b101010, 32'd1,        32'hFFFFFFFF, 32'd0,        7'b1001000, 2'b10, 4'b0111, 32'd0,        1'b1};
        vecs[4]  = '{"and",      6'b000000, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        7'b1001000, 2'b10, 4'b0000, 32'hF000F000, 1'b0};
        vecs[5]  = '{"or",       6'b000000, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        7'b1001000, 2'b10, 4'b0001, 32'hFFF0FFF0, 1'b0};
        vecs[6]  = '{"xor",      6'b000000, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        7'b1001000, 2'b10, 4'b1101, 32'h0FF00FF0, 1'b0};
        vecs[7]  = '{"nor",      6'b000000, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        7'b1001000, 2'b10, 4'b1100, 32'h000F000F, 1'b0};
        vecs[8]  = '{"bad_fn",   6'b000000, 6'b000001, 32'd5,        32'd7,        32'd0,        7'b1001000, 2'b10, 4'b1111, 32'd0,        1'b1};
        vecs[9]  = '{"lw",       6'b100011, 6'b000000, 32'h100,      32'hDEAD,     32'h10,       7'b0111100, 2'b00, 4'b0010, 32'h110,      1'b0};
        vecs[10] = '{"sw",       6'b101011, 6'b000000, 32'h20,       32'h12345678, 32'hFFFFFFFC, 7'b0100010, 2'b00, 4'b0010, 32'h1C,       1'b0};
        vecs[11] = '{"beq_eq",   6'b000100, 6'b000000, 32'd3,        32'd3,        32'd8,        7'b0000001, 2'b01, 4'b0110, 32'd0,        1'b1};
        vecs[12] = '{"beq_ne",   6'b000100, 6'b000000, 32'd3,        32'd5,        32'd8,        7'b0000001, 2'b01, 4'b0110, 32'hFFFFFFFE, 1'b0};
        vecs[13] = '{"addi",     6'b001000, 6'b000000, 32'h7FFFFFFF, 32'd9,        32'd1,        7'b0101000, 2'b00, 4'b0010, 32'h80000000, 1'b0};
        vecs[14] = '{"bad_op",   6'b111111, 6'b100010, 32'd5,        32'd7,        32'd100,      7'b0000000, 2'b00, 4'b0010, 32'd12,       1'b0};
        vecs[15] = '{"sub_wrap", 6'b000000, 6'b100010, 32'd0,        32'd1,        32'd0,        7'b1001000, 2'b10, 4'b0110, 32'hFFFFFFFF, 1'b0};

        reset = 1'b1; flush = 1'b0;
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        repeat (2) @(posedge clk);
        #1 check_q_clear("reset_state");

        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].fn, vecs[i].va, vecs[i].vb, vecs[i].vi);
            #1;
            check({vecs[i].name, ".ctl"},
                  {25'h0, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch},
                  {25'h0, vecs[i].ctl});
            check({vecs[i].name, ".aluop"},   {30'h0, aluop},  {30'h0, vecs[i].aop});
            check({vecs[i].name, ".aluctl"},  {28'h0, aluctl}, {28'h0, vecs[i].actl});
            check({vecs[i].name, ".alu_out"}, alu_out, vecs[i].res);
            check({vecs[i].name, ".zero"},    {31'h0, zero},   {31'h0, vecs[i].z});
            @(posedge clk);
            #1;
            check({vecs[i].name, ".q_result"},     q_result, vecs[i].res);
            check({vecs[i].name, ".q_store_data"}, q_store_data, vecs[i].vb);
            check({vecs[i].name, ".q_flags"},
                  {26'h0, q_zero, q_regwrite, q_memtoreg, q_memread, q_memwrite, q_branch},
                  {26'h0, vecs[i].z, vecs[i].ctl[3], vecs[i].ctl[4], vecs[i].ctl[2],
                   vecs[i].ctl[1], vecs[i].ctl[0]});
        end

        // Each clear case is preceded by a normal load so the clear is observable.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reset = 1'b0; flush = 1'b0;
            drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
            @(posedge clk);
            #1 check("preload.q_result", q_result, 32'd12);
            @(negedge clk);
            reset = (k != 1);
            flush = (k != 0);
            @(posedge clk);
            #1;
            case (k)
                0:       check_q_clear("reset_only");
                1:       check_q_clear("flush_only");
                default: check_q_clear("reset_and_flush");
            endcase
            #1 check("comb_during_clear.alu_out", alu_out, 32'd12);
        end

        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        drive(6'b100011, 6'b000000, 32'h100, 32'hDEAD, 32'h10);
        @(posedge clk);
        #1;
        check("reload.q_result",     q_result, 32'h110);
        check("reload.q_store_data", q_store_data, 32'hDEAD);
        check("reload.q_flags",
              {26'h0, q_zero, q_regwrite, q_memtoreg, q_memread, q_memwrite, q_branch},
              32'b011100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_decode_exec_unit.md
Name: mips_decode_exec_unit

Overview:
- Single-cycle decode-and-execute slice for the five-stage MIPS core.
- Decodes a 6-bit opcode into datapath control signals.
- Derives a 4-bit ALU operation from the decoded ALU op class and the funct field, then executes a 32-bit ALU operation.
- Registers the result, zero flag and downstream control bits into an EX/MEM-style output register.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of the output register (bubble insert)
- opcode  input  6  instruction bits [31:26]
- funct  input  6  instruction bits [5:0]
- a  input  32  ALU operand A (rs value)
- b_reg  input  32  rt register value
- imm_se  input  32  sign-extended immediate
- regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc  output  1 each  combinational decode
- aluop  output  2  combinational ALU op class
- aluctl  output  4  combinational ALU operation
- alu_out  output  32  combinational ALU result
- zero  output  1  combinational, 1 when alu_out == 0
- q_result  output  32  registered alu_out
- q_zero  output  1  registered zero
- q_store_data  output  32  registered b_reg
- q_regwrite, q_memtoreg, q_memread, q_memwrite, q_branch  output  1 each  registered control

Behaviour:
- Decode (combinational, listed as regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop):
  - 000000 R-type: 1,0,0,1,0,0,0,10
  - 100011 lw: 0,1,1,1,1,0,0,00
  - 101011 sw: 0,1,0,0,0,1,0,00
  - 000100 beq: 0,0,0,0,0,0,1,01
  - 001000 addi: 0,1,0,1,0,0,0,00
  - any other opcode: all zero, aluop=00
- ALU control (combinational):
  - aluop 00 -> 0010 (add)
  - aluop 01 -> 0110 (sub)
  - aluop 11 -> 1111
  - aluop 10, decode by funct: 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and; 100101 -> 0001 or; 100110 -> 1101 xor; 100111 -> 1100 nor; 101010 -> 0111 slt; other funct -> 1111
- ALU operand B = alusrc ? imm_se : b_reg.
- ALU operations:
  - 0010 a+b, 0110 a-b; modulo 2^32, carry and overflow ignored
  - 0000 a&b, 0001 a|b, 1101 a^b, 1100 ~(a|b)
  - 0111 signed compare: 32'd1 if $signed(a) < $signed(b), else 0
  - 1111 and any unlisted code: output 0
- zero = (alu_out == 0), including the case where alu_out is forced 0 by an illegal code.
- Output register, on rising clk:
  - Priority: reset > flush > load.
  - reset or flush: all q_* outputs go to 0.
  - Otherwise: q_result <= alu_out, q_zero <= zero, q_store_data <= b_reg, q_* control <= corresponding decode outputs.
  - Latency: combinational outputs 0 cycles; q_* outputs 1 cycle.
- Reset asserted mid-stream clears the register on that edge; the first load occurs on the first edge with reset low.
- Combinational outputs do not depend on reset.

Test Plan:
- R-type add: opcode=000000, funct=100000, a=5, b_reg=7 -> aluctl=0010, alu_out=12, zero=0, regdst=1, regwrite=1; after 1 clk q_result=12, q_regwrite=1.
- R-type sub to zero and slt signed: funct=100010, a=b_reg=9 -> alu_out=0, zero=1. funct=101010, a=0xFFFFFFFF, b_reg=1 -> alu_out=1.
- lw: opcode=100011, a=0x100, imm_se=0x10, b_reg=0xDEAD -> alusrc=1, alu_out=0x110, memread=1, memtoreg=1; after clk q_memread=1, q_result=0x110.
- sw and beq:
  - sw: opcode=101011, a=0x20, imm_se=0xFFFFFFFC -> alu_out=0x1C, memwrite=1, regwrite=0; after clk q_store_data=b_reg.
  - beq: opcode=000100, a=b_reg=3 -> aluctl=0110, zero=1, branch=1; after clk q_branch=1, q_zero=1.
- Illegal decode: opcode=111111 -> all control 0, aluctl=0010. opcode=000000 with funct=000001 -> aluctl=1111, alu_out=0, zero=1.
- Reset/flush:
  - reset=1 with flush=0 and an add in progress -> all q_*=0 next edge.
  - flush=1 with reset=0 -> all q_*=0.
  - Both high -> all q_*=0.
  - Next edge with both low loads normally.
